// File: rtl/uart_frame_rx.sv
// UART receive-side frame assembler: packs NUM_BYTES received bytes into one wide word,
// first byte in the least-significant position, dropping partial frames after an idle timeout.
module uart_frame_rx #(
  parameter int unsigned NUM_BYTES      = 40,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_read_done,
  input  logic [7:0]             read_data,
  input  logic                   recv_en,
  output logic [8*NUM_BYTES-1:0] data,
  output logic                   recv_done,
  output logic                   frame_err,
  output logic                   busy,
  output logic [7:0]             byte_cnt
);

  localparam int unsigned      DATA_W   = 8 * NUM_BYTES;
  localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              rd_prev_q;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              recv_done_q, recv_done_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;

  logic strobe_c, accept_c, last_c, timeout_c;

  // Rising edge of uart_read_done; recv_en only gates the first byte of a frame.
  assign strobe_c  = uart_read_done & ~rd_prev_q;
  assign accept_c  = strobe_c & ((state_q == COLLECT) | recv_en);
  assign last_c    = (byte_cnt_q == LAST_IDX);
  assign timeout_c = (state_q == COLLECT) & ~strobe_c & (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c && !last_c) state_d = COLLECT;
      COLLECT: if ((accept_c && last_c) || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow write, frame commit and timeout bookkeeping.
  always_comb begin
    shadow_d    = shadow_q;
    data_d      = data_q;
    recv_done_d = 1'b0;
    frame_err_d = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    if (accept_c) begin
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
        if (byte_cnt_q == 8'(k)) shadow_d[8*k +: 8] = read_data;
      end
      tmo_d = '0;
      if (last_c) begin
        data_d      = shadow_d;
        recv_done_d = 1'b1;
        byte_cnt_d  = 8'd0;
      end else begin
        byte_cnt_d  = byte_cnt_q + 8'd1;
      end
    end else if (timeout_c) begin
      frame_err_d = 1'b1;
      byte_cnt_d  = 8'd0;
      tmo_d       = '0;
    end else if (state_q == COLLECT) begin
      tmo_d = tmo_q + CNT_W'(1);
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_prev_q   <= 1'b1;
      shadow_q    <= '0;
      data_q      <= '0;
      recv_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      byte_cnt_q  <= 8'd0;
      tmo_q       <= '0;
    end else begin
      rd_prev_q   <= uart_read_done;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      recv_done_q <= recv_done_d;
      frame_err_q <= frame_err_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign data      = data_q;
  assign recv_done = recv_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == COLLECT);
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: randomized byte stream, frame-level reference model and
// an event scoreboard drained by a monitor on recv_done / frame_err.
module tb_uart_frame_rx;

  localparam int unsigned NB  = 40;
  localparam int unsigned TMO = 50;
  localparam int unsigned DW  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_read_done = 1'b0;
  logic [7:0]    read_data = 8'h00;
  logic          recv_en = 1'b1;
  logic [DW-1:0] data;
  logic          recv_done;
  logic          frame_err;
  logic          busy;
  logic [7:0]    byte_cnt;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] d;
    int unsigned   at;
  } ev_t;
  ev_t exp_q[$];

  // Reference model: bytes of the open frame, last delivered frame, time of last accepted byte.
  logic [7:0]    m_bytes[$];
  logic [DW-1:0] m_data = '0;
  bit            m_busy = 1'b0;
  int unsigned   m_last = 0;

  uart_frame_rx #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .uart_read_done(uart_read_done), .read_data(read_data),
    .recv_en(recv_en), .data(data), .recv_done(recv_done), .frame_err(frame_err),
    .busy(busy), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack_frame();
    logic [DW-1:0] r;
    r = '0;
    foreach (m_bytes[k]) r[8*k +: 8] = m_bytes[k];
    return r;
  endfunction

  task automatic push_err();
    exp_q.push_back('{1'b1, m_data, m_last + TMO});
    m_busy = 1'b0;
    m_bytes.delete();
  endtask

  task automatic check_state(input string name);
    chk({name, "_byte_cnt"}, DW'(byte_cnt), DW'(m_bytes.size()));
    chk({name, "_busy"}, DW'(busy), DW'(m_busy));
  endtask

  // Line low for gap cycles, then high for hold cycles; the strobe edge is cyc+gap+1.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input int unsigned hold);
    int unsigned c;
    c = cyc + gap + 1;
    if (m_busy && c > m_last + TMO) push_err();
    if (m_busy || recv_en) begin
      m_bytes.push_back(b);
      m_busy = 1'b1;
      m_last = c;
      if (m_bytes.size() == NB) begin
        m_data = pack_frame();
        exp_q.push_back('{1'b0, m_data, c});
        m_busy = 1'b0;
        m_bytes.delete();
      end
    end
    repeat (gap) tick();
    uart_read_done = 1'b1;
    read_data = b;
    repeat (hold) tick();
    uart_read_done = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    if (m_busy && cyc + n >= m_last + TMO) push_err();
    repeat (n) tick();
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    repeat (n) tick();
    m_busy = 1'b0;
    m_bytes.delete();
    m_data = '0;
    chk("rst_data", data, '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_byte_cnt", DW'(byte_cnt), '0);
    chk("rst_recv_done", DW'(recv_done), '0);
    chk("rst_frame_err", DW'(frame_err), '0);
    rst = 1'b0;
  endtask

  task automatic send_random_bytes(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      send_byte(8'($urandom), 1 + $urandom_range(0, 7), 1 + $urandom_range(0, 3));
      check_state("rand");
    end
  endtask

  // Monitor: every recv_done / frame_err pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (recv_done || frame_err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event at cycle %0d: recv_done=%0b frame_err=%0b", cyc, recv_done, frame_err);
      end else begin
        e = exp_q.pop_front();
        chk("ev_frame_err", DW'(frame_err), DW'(e.is_err));
        chk("ev_recv_done", DW'(recv_done), DW'(!e.is_err));
        chk("ev_cycle", DW'(cyc), DW'(e.at));
        chk("ev_data", data, e.d);
        chk("ev_busy", DW'(busy), '0);
        chk("ev_byte_cnt", DW'(byte_cnt), '0);
      end
    end
  end

  initial begin
    logic [DW-1:0] a5;
    a5 = {NB{8'hA5}};

    do_reset(3);

    // Full frame of ascending bytes with long strobes.
    for (int i = 0; i < int'(NB); i++) begin
      send_byte(8'(i), 10, 3);
      check_state("seq");
    end
    chk("seq_low_byte", DW'(data[7:0]), DW'(8'h00));
    chk("seq_high_byte", DW'(data[DW-1 -: 8]), DW'(8'h27));

    // Partial frame dropped by timeout, then a 0xA5 frame.
    send_random_bytes(5);
    idle(60);
    check_state("tmo");
    for (int i = 0; i < int'(NB); i++) send_byte(8'hA5, 2, 1);
    chk("a5_frame", data, a5);

    // recv_en low ignores bytes; it only matters for the first byte.
    recv_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), 3, 2);
      check_state("disabled");
    end
    recv_en = 1'b1;
    send_random_bytes(2);
    recv_en = 1'b0;
    send_random_bytes(NB - 2);
    recv_en = 1'b1;
    check_state("en_frame");

    // Strobe on the terminal-count cycle wins; one cycle later times out.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 5, 3);
    send_byte(8'h44, 47, 3);
    chk("tc_byte_cnt", DW'(byte_cnt), DW'(8'd4));
    check_state("tc");
    send_byte(8'h55, 48, 3);
    chk("tc_late_byte_cnt", DW'(byte_cnt), DW'(8'd1));
    send_random_bytes(NB - 1);
    idle(3);

    // uart_read_done held high across reset release must not count.
    uart_read_done = 1'b1;
    do_reset(2);
    repeat (3) tick();
    uart_read_done = 1'b0;
    send_byte(8'h3C, 2, 2);
    chk("held_byte_cnt", DW'(byte_cnt), DW'(8'd1));
    idle(60);

    // Reset mid-frame, then a clean frame.
    send_random_bytes(20);
    do_reset(1);
    send_random_bytes(NB);

    // Random traffic with occasional long gaps and recv_en toggling.
    for (int i = 0; i < 150; i++) begin
      recv_en = ($urandom_range(0, 3) != 0);
      send_byte(8'($urandom),
                ($urandom_range(0, 9) == 0) ? 40 + $urandom_range(0, 14) : 1 + $urandom_range(0, 7),
                1 + $urandom_range(0, 3));
      check_state("mix");
    end

    recv_en = 1'b1;
    idle(100);
    chk("pending_events", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Receive-side frame assembler for the UART link. It collects a fixed-length stream of bytes from the UART byte receiver and packs them into one wide word. The first byte received goes into the least-significant byte. It sits between the UART receiver and the application logic. It is the counterpart of the 40-byte (320-bit) frame transmit controller, so a frame sent by that controller is reassembled here with identical bit ordering.

Parameters:
NUM_BYTES, 40, bytes per frame; data width is 8*NUM_BYTES.
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles allowed between two bytes of one frame; must be at least 2.
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset; synchronous, active-high.
uart_read_done  in  1  byte-ready flag from the UART receiver; may be held high for several cycles.
read_data  in  8  received byte; valid whenever uart_read_done=1.
recv_en  in  1  frame-start enable; sampled only when the first byte of a frame arrives.
data  out  8*NUM_BYTES  last complete frame; byte k is in data[8k+7:8k].
recv_done  out  1  one-cycle pulse when data has been updated with a new frame.
frame_err  out  1  one-cycle pulse when a partial frame is discarded on timeout.
busy  out  1  high while a frame is partially collected.
byte_cnt  out  8  bytes collected so far in the current frame (0..NUM_BYTES-1).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: data=0, recv_done=0, frame_err=0, busy=0, byte_cnt=0, shadow buffer=0, timeout counter=0. The edge-detect register resets to 1, so a uart_read_done already held high at reset release is not counted as a byte.
- Byte strobe: a byte is accepted on the clk edge where uart_read_done=1 and the registered previous value of uart_read_done is 0. One byte is accepted per rising edge of uart_read_done, no matter how long it stays high.
- State machine has two states:
  - IDLE: busy=0, byte_cnt=0.
    - Byte strobe with recv_en=1: write the byte to shadow[7:0], set byte_cnt=1, go to COLLECT. If NUM_BYTES=1, complete the frame immediately instead and stay in IDLE.
    - Byte strobe with recv_en=0: discard the byte and stay in IDLE.
  - COLLECT: busy=1.
    - Byte strobe: write shadow[8*byte_cnt +: 8], then increment byte_cnt.
    - If the accepted byte is number NUM_BYTES-1: copy the whole shadow buffer, including this byte, into data. recv_done=1 in the next cycle, byte_cnt returns to 0, go to IDLE.
    - recv_en changes are ignored in this state.
- Output update: data changes only on frame completion, all bits in the same cycle, so it is never partially written. data holds its value until the next completed frame.
- Latency: the last byte is sampled on edge t. data and recv_done are valid in the cycle after edge t, and recv_done is high for exactly that one cycle.
- Timeout counter:
  - Cleared on every accepted byte and whenever the block is in IDLE.
  - Increments each cycle in COLLECT with no byte strobe.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe that cycle: pulse frame_err for one cycle, set byte_cnt=0, go to IDLE, and leave data unchanged. The shadow buffer keeps its stale contents, which are overwritten by the next frame.
- Simultaneous byte strobe and timeout terminal count: the byte wins; it is accepted, the counter is cleared, and no frame_err is raised.
- A frame may complete in the same cycle that a new strobe would start the next frame. This cannot happen, because the edge detector needs uart_read_done to fall first.
- recv_done and frame_err are never high in the same cycle.
- Reset mid-frame: the partial frame is dropped and all outputs return to their reset values on the next edge, including data=0.
- Width rules: byte_cnt is zero-extended to 8 bits; NUM_BYTES ≤ 255. Write indexing uses byte_cnt directly, with no wrap beyond NUM_BYTES-1.

Test Plan:
- Reset with recv_en=1, then send 40 bytes 0x00..0x27, each strobe held 3 cycles, gap 10 cycles. Expected: one recv_done pulse the cycle after the 40th strobe edge; data[7:0]=0x00, data[319:312]=0x27; busy falls with recv_done.
- Send 5 bytes, then stay idle with TIMEOUT_CYCLES=50. Expected: frame_err pulses once at 50 idle cycles, byte_cnt=0, data unchanged. A following full frame of 0xA5 bytes gives data equal to 0xA5 repeated 40 times.
- Send bytes while recv_en=0. Expected: no busy, byte_cnt stays 0, no recv_done. Then raise recv_en, send 2 bytes and drop recv_en, then send 38 more. Expected: a full frame is received.
- TIMEOUT_CYCLES=50 with the 4th byte strobe landing exactly on the terminal-count cycle. Expected: the byte is accepted, byte_cnt=4, no frame_err.
- Hold uart_read_done high across reset release, then low, then one pulse. Expected: byte_cnt=1, not 2.
- Assert rst after 20 bytes. Expected: next cycle data=0, busy=0, byte_cnt=0. A following 40-byte frame completes normally.
